imem_boot_loader: RTL and testbench

Upstream loader for the single-cycle RISC-V core: accepts a byte stream on a valid/ready interface and assembles little-endian 32-bit instruction words. It writes them sequentially into the instruction memory write port and holds the core in reset until the whole program is written. It sits between the host byte source (UART RX or testbench driver) and the `top_2` instruction memory and reset input.

---
 rtl/boot_pkg.sv | 17 +
 rtl/boot_byte_assembler.sv | 32 +++
 rtl/imem_boot_loader.sv | 140 ++++++++++++++
 tb/tb_imem_boot_loader.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/boot_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package boot_pkg;

    // Loader states; CHK is only reachable when BOOT_CHECKSUM_EN is defined
    typedef enum logic [2:0] {
        HDR_LO,
        HDR_HI,
        DATA,
        CHK,
        DONE,
        ERROR
    } boot_state_t;

    localparam int HDR_BYTES  = 2;
    localparam int WORD_BYTES = 4;

endpackage

// File: rtl/boot_byte_assembler.sv
// Collects four accepted bytes (LSB first) into one 32-bit instruction word.
// word/word_ready are combinational so the completed word is available on
// the same edge that accepts its last byte.
module boot_byte_assembler
    import boot_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        accept,
    input  logic [7:0]  rx_byte,
    output logic        word_ready,
    output logic [31:0] word
);

    logic [1:0]  cnt;
    logic [23:0] partial;

    assign word_ready = accept && (cnt == 2'(WORD_BYTES - 1));
    assign word       = {rx_byte, partial};

    // Byte counter and shift register; hold while no byte is accepted
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            partial <= '0;
        end else if (accept) begin
            cnt     <= cnt + 2'd1;
            partial <= {rx_byte, partial[23:8]};
        end
    end

endmodule

// File: rtl/imem_boot_loader.sv
// Byte-stream boot loader: parses a 16-bit word count header, writes the
// following little-endian words into instruction memory and releases the
// core reset once the program is in place.
// Optional feature macro: BOOT_CHECKSUM_EN (trailing XOR checksum byte).
module imem_boot_loader
    import boot_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_reset,
    output logic              boot_done,
    output logic              boot_error,
    output logic [ADDR_W:0]   words_loaded
);

    localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;

`ifdef BOOT_CHECKSUM_EN
    localparam boot_state_t AFTER_DATA = CHK;
`else
    localparam boot_state_t AFTER_DATA = DONE;
`endif

    boot_state_t state, state_n;
    logic [7:0]  n_lo;
    logic [16:0] n_words;
    logic [16:0] n_hdr;
    logic [16:0] words_next;
    logic        accept;
    logic        word_ready;
    logic [31:0] word;

    assign rx_ready   = !reset && (state inside {HDR_LO, HDR_HI, DATA, CHK});
    assign accept     = rx_valid && rx_ready;
    assign n_hdr      = {1'b0, rx_data, n_lo};
    assign words_next = 17'(words_loaded) + 17'd1;

    boot_byte_assembler u_asm (
        .clk        (clk),
        .reset      (reset),
        .accept     (accept && (state == DATA)),
        .rx_byte    (rx_data),
        .word_ready (word_ready),
        .word       (word)
    );

`ifdef BOOT_CHECKSUM_EN
    logic [7:0] csum;

    // Running XOR over header and data bytes
    always_ff @(posedge clk) begin
        if (reset) begin
            csum <= '0;
        end else if (accept && (state inside {HDR_LO, HDR_HI, DATA})) begin
            csum <= csum ^ rx_data;
        end
    end
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= HDR_LO;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        case (state)
            HDR_LO: if (accept) state_n = HDR_HI;
            HDR_HI: begin
                if (accept) begin
                    if (n_hdr > MAX_WORDS)  state_n = ERROR;
                    else if (n_hdr == '0)   state_n = AFTER_DATA;
                    else                    state_n = DATA;
                end
            end
            DATA: if (word_ready && (words_next == n_words)) state_n = AFTER_DATA;
`ifdef BOOT_CHECKSUM_EN
            CHK: if (accept) state_n = (rx_data == csum) ? DONE : ERROR;
`endif
            default: state_n = state;
        endcase
    end

    // Header capture: low byte, then the full word count
    always_ff @(posedge clk) begin
        if (reset) begin
            n_lo    <= '0;
            n_words <= '0;
        end else begin
            if (accept && (state == HDR_LO)) n_lo <= rx_data;
            if (accept && (state == HDR_HI)) n_words <= n_hdr;
        end
    end

    // Instruction memory write port; one pulse per completed word
    always_ff @(posedge clk) begin
        if (reset) begin
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= '0;
            words_loaded <= '0;
        end else begin
            imem_we <= word_ready;
            if (word_ready) begin
                imem_addr    <= words_loaded[ADDR_W-1:0];
                imem_wdata   <= word;
                words_loaded <= words_next[ADDR_W:0];
            end
        end
    end

    // Sticky status; core released one cycle after DONE so the last write lands first
    always_ff @(posedge clk) begin
        if (reset) begin
            core_reset <= 1'b1;
            boot_done  <= 1'b0;
            boot_error <= 1'b0;
        end else begin
            if (state == DONE) begin
                core_reset <= 1'b0;
                boot_done  <= 1'b1;
            end
            if (state_n == ERROR) boot_error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader (ADDR_W=4, depth 16 words).
module tb_imem_boot_loader;

    localparam int ADDR_W = 4;
    localparam int DEPTH  = 1 << ADDR_W;
`ifdef BOOT_CHECKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              rx_valid = 1'b0;
    logic [7:0]        rx_data = '0;
    logic              rx_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              core_reset;
    logic              boot_done;
    logic              boot_error;
    logic [ADDR_W:0]   words_loaded;

    int checks = 0;
    int errors = 0;

    logic [7:0]  bytes_q[$];
    logic [31:0] exp_words[$];
    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];

    typedef struct {
        int n;
        bit bad_chk;
        int gap_pct;
        bit exp_err;
        int exp_wl;
    } vec_t;

    imem_boot_loader #(.ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rx_ready     (rx_ready),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .core_reset   (core_reset),
        .boot_done    (boot_done),
        .boot_error   (boot_error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    // Log every write pulse, sampled mid-cycle; a stretched pulse logs twice
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            wr_addr.push_back(32'(imem_addr));
            wr_data.push_back(imem_wdata);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rx_valid = 1'b0;
        reset    = 1'b1;
        #1;
        check("rx_ready_in_reset", 32'(rx_ready), 0);
        tick();
        tick();
        check("rst_we", 32'(imem_we), 0);
        check("rst_addr", 32'(imem_addr), 0);
        check("rst_wdata", imem_wdata, 0);
        check("rst_core_reset", 32'(core_reset), 1);
        check("rst_done", 32'(boot_done), 0);
        check("rst_error", 32'(boot_error), 0);
        check("rst_words", 32'(words_loaded), 0);
        reset = 1'b0;
        #1;
        check("ready_after_reset", 32'(rx_ready), 1);
        wr_addr.delete();
        wr_data.delete();
    endtask

    // Reference stream: header, random words, optional XOR trailer
    task automatic build_stream(input int n, input bit bad);
        logic [7:0]  x;
        logic [31:0] w;
        bytes_q.delete();
        exp_words.delete();
        bytes_q.push_back(n[7:0]);
        bytes_q.push_back(n[15:8]);
        if (n <= DEPTH) begin
            for (int k = 0; k < n; k++) begin
                w = $urandom;
                exp_words.push_back(w);
                for (int j = 0; j < 4; j++) bytes_q.push_back(w[8*j +: 8]);
            end
            if (CHK_EN) begin
                x = 8'h00;
                foreach (bytes_q[i]) x = x ^ bytes_q[i];
                if (bad) x = x ^ 8'($urandom_range(1, 255));
                bytes_q.push_back(x);
            end
        end
    endtask

    // Drive bytes from index first to last, with random idle cycles
    task automatic send_bytes(input int first, input int last, input int gap_pct);
        for (int i = first; i <= last; i++) begin
            while (int'($urandom_range(0, 99)) < gap_pct) begin
                rx_valid = 1'b0;
                rx_data  = 8'($urandom);
                tick();
            end
            if (!rx_ready) break;
            rx_valid = 1'b1;
            rx_data  = bytes_q[i];
            tick();
        end
        rx_valid = 1'b0;
    endtask

    task automatic check_outcome(input string tag, input bit exp_err, input int exp_wl);
        for (int c = 0; c < 3; c++) tick();
        check({tag, "_done"}, 32'(boot_done), 32'(!exp_err));
        check({tag, "_error"}, 32'(boot_error), 32'(exp_err));
        check({tag, "_core_reset"}, 32'(core_reset), 32'(exp_err));
        check({tag, "_ready"}, 32'(rx_ready), 0);
        check({tag, "_words"}, 32'(words_loaded), 32'(exp_wl));
        check({tag, "_nwrites"}, 32'(wr_addr.size()), 32'(exp_wl));
        for (int k = 0; k < exp_wl && k < wr_addr.size(); k++) begin
            check({tag, "_waddr"}, wr_addr[k], 32'(k));
            check({tag, "_wdata"}, wr_data[k], exp_words[k]);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t        vecs[10];
        logic [7:0]  seq[$];
        logic [7:0]  x;
        int          n;
        bit          e;

        vecs[0] = '{n: 2,      bad_chk: 0, gap_pct: 0,  exp_err: 0,      exp_wl: 2};
        vecs[1] = '{n: 0,      bad_chk: 0, gap_pct: 0,  exp_err: 0,      exp_wl: 0};
        vecs[2] = '{n: 16,     bad_chk: 0, gap_pct: 0,  exp_err: 0,      exp_wl: 16};
        vecs[3] = '{n: 17,     bad_chk: 0, gap_pct: 0,  exp_err: 1,      exp_wl: 0};
        vecs[4] = '{n: 1,      bad_chk: 1, gap_pct: 0,  exp_err: CHK_EN, exp_wl: 1};
        vecs[5] = '{n: 5,      bad_chk: 0, gap_pct: 40, exp_err: 0,      exp_wl: 5};
        vecs[6] = '{n: 3,      bad_chk: 1, gap_pct: 50, exp_err: CHK_EN, exp_wl: 3};
        vecs[7] = '{n: 'h1234, bad_chk: 0, gap_pct: 0,  exp_err: 1,      exp_wl: 0};
        vecs[8] = '{n: 1,      bad_chk: 0, gap_pct: 60, exp_err: 0,      exp_wl: 1};
        vecs[9] = '{n: 'hffff, bad_chk: 0, gap_pct: 20, exp_err: 1,      exp_wl: 0};

        // Known program, one byte per cycle, cycle-exact write and release timing
        do_reset();
        seq = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h00, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
        if (CHK_EN) begin
            x = 8'h00;
            foreach (seq[i]) x = x ^ seq[i];
            seq.push_back(x);
        end
        foreach (seq[i]) begin
            rx_valid = 1'b1;
            rx_data  = seq[i];
            tick();
            if (i == 5) begin
                check("p_we0", 32'(imem_we), 1);
                check("p_addr0", 32'(imem_addr), 0);
                check("p_data0", imem_wdata, 32'h00000513);
            end else if (i == 9) begin
                check("p_we1", 32'(imem_we), 1);
                check("p_addr1", 32'(imem_addr), 1);
                check("p_data1", imem_wdata, 32'h00100593);
                check("p_words", 32'(words_loaded), 2);
            end else begin
                check("p_we_idle", 32'(imem_we), 0);
            end
        end
        rx_valid = 1'b0;
        check("p_done_not_yet", 32'(boot_done), 0);
        check("p_core_held", 32'(core_reset), 1);
        tick();
        check("p_done", 32'(boot_done), 1);
        check("p_core_released", 32'(core_reset), 0);
        check("p_we_after", 32'(imem_we), 0);
        check("p_nwrites", 32'(wr_addr.size()), 2);

        // Table of streams
        for (int v = 0; v < 10; v++) begin
            do_reset();
            build_stream(vecs[v].n, vecs[v].bad_chk);
            send_bytes(0, bytes_q.size() - 1, vecs[v].gap_pct);
            check_outcome($sformatf("vec%0d", v), vecs[v].exp_err, vecs[v].exp_wl);
        end

        // Random streams against the model
        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(0, DEPTH + 3);
            e = n > DEPTH;
            do_reset();
            build_stream(n, 1'b0);
            send_bytes(0, bytes_q.size() - 1, $urandom_range(0, 60));
            check_outcome($sformatf("rnd%0d", r), e, e ? 0 : n);
        end

        // Reset in the middle of word 1, then a full reload
        do_reset();
        build_stream(3, 1'b0);
        send_bytes(0, 7, 50);
        tick();
        reset = 1'b1;
        #1;
        check("mid_ready_in_reset", 32'(rx_ready), 0);
        tick();
        check("mid_we", 32'(imem_we), 0);
        check("mid_words", 32'(words_loaded), 0);
        check("mid_core_reset", 32'(core_reset), 1);
        check("mid_nwrites", 32'(wr_addr.size()), 1);
        if (wr_data.size() > 0) check("mid_word0", wr_data[0], exp_words[0]);
        reset = 1'b0;
        #1;
        check("mid_ready_after", 32'(rx_ready), 1);
        wr_addr.delete();
        wr_data.delete();
        build_stream(4, 1'b0);
        send_bytes(0, bytes_q.size() - 1, 30);
        check_outcome("reload", 1'b0, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
